// File: rtl/planificador_ascensor_pkg.sv
// Shared types and constants for the four-floor elevator scheduler.
// Direction codes, FSM states and the above/below call mask helpers.
package planificador_ascensor_pkg;

  localparam int N_PISOS = 4;

  localparam logic [1:0] DIR_REPOSO = 2'b00;
  localparam logic [1:0] DIR_SUBE   = 2'b01;
  localparam logic [1:0] DIR_BAJA   = 2'b10;

  typedef enum logic [1:0] {
    REPOSO   = 2'b00,
    MOVIENDO = 2'b01,
    PUERTAS  = 2'b10
  } estado_t;

  function automatic logic [N_PISOS-1:0] mascara_arriba(
    input logic [1:0] p
  );
    logic [N_PISOS-1:0] m;
    m = '0;
    for (int i = 0; i < N_PISOS; i++) begin
      m[i] = (i > int'(p));
    end
    return m;
  endfunction

  function automatic logic [N_PISOS-1:0] mascara_abajo(
    input logic [1:0] p
  );
    logic [N_PISOS-1:0] m;
    m = '0;
    for (int i = 0; i < N_PISOS; i++) begin
      m[i] = (i < int'(p));
    end
    return m;
  endfunction

endpackage

// File: rtl/planificador_ascensor_temporizador_tick.sv
// Tick-driven 4-bit interval counter: load clears, each tick counts,
// fin pulses on the tick that reaches limite and the count wraps to 0.
module temporizador_tick (
  input  logic       clk,
  input  logic       rst,
  input  logic       carga,
  input  logic       tick,
  input  logic [3:0] limite,
  output logic       fin
);

  logic [3:0] cuenta_q;
  logic [3:0] cuenta_d;

  always_comb begin
    fin      = 1'b0;
    cuenta_d = cuenta_q;
    if (carga) begin
      cuenta_d = '0;
    end else if (tick) begin
      if (cuenta_q + 4'd1 == limite) begin
        fin      = 1'b1;
        cuenta_d = '0;
      end else begin
        cuenta_d = cuenta_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

endmodule

// File: rtl/planificador_ascensor.sv
// Four-floor elevator scheduler: latches calls, picks a sweep direction,
// travels floor by floor on tick pulses and holds the doors open.
module planificador_ascensor
  import planificador_ascensor_pkg::*;
#(
  parameter int unsigned T_VIAJE  = 4,
  parameter int unsigned T_PUERTA = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [N_PISOS-1:0] boton_piso,
  output logic [1:0]         piso,
  output logic [1:0]         direccion,
  output logic               puertas_abiertas,
  output logic               state_andando,
  output logic [N_PISOS-1:0] pendientes
);

  localparam logic [3:0] LIM_VIAJE  = 4'(T_VIAJE);
  localparam logic [3:0] LIM_PUERTA = 4'(T_PUERTA);

  estado_t            estado_q, estado_d;
  logic [1:0]         piso_q, piso_d;
  logic [1:0]         dir_q, dir_d;
  logic               ult_q, ult_d;
  logic [N_PISOS-1:0] pend_q, pend_d;

  logic hay_arriba;
  logic hay_abajo;
  logic sube;
  logic carga_viaje;
  logic carga_puerta;
  logic fin_viaje;
  logic fin_puerta;

  assign hay_arriba = |(pend_q & mascara_arriba(piso_q));
  assign hay_abajo  = |(pend_q & mascara_abajo(piso_q));

  // Timers sit cleared outside their state; a call at this floor re-arms the doors.
  assign carga_viaje  = (estado_q != MOVIENDO);
  assign carga_puerta = (estado_q != PUERTAS) || boton_piso[piso_q];

  temporizador_tick u_viaje (
    .clk    (clk),
    .rst    (rst),
    .carga  (carga_viaje),
    .tick   (tick),
    .limite (LIM_VIAJE),
    .fin    (fin_viaje)
  );

  temporizador_tick u_puerta (
    .clk    (clk),
    .rst    (rst),
    .carga  (carga_puerta),
    .tick   (tick),
    .limite (LIM_PUERTA),
    .fin    (fin_puerta)
  );

  always_comb begin
    estado_d = estado_q;
    piso_d   = piso_q;
    dir_d    = dir_q;
    ult_d    = ult_q;
    pend_d   = pend_q | boton_piso;
    sube     = ult_q ? hay_arriba : ~hay_abajo;
    case (estado_q)
      REPOSO: begin
        dir_d = DIR_REPOSO;
        if (pend_q[piso_q]) begin
          estado_d = PUERTAS;
        end else if (hay_arriba || hay_abajo) begin
          estado_d = MOVIENDO;
          dir_d    = sube ? DIR_SUBE : DIR_BAJA;
          ult_d    = sube;
        end
      end
      MOVIENDO: begin
        if (fin_viaje) begin
          if (dir_q == DIR_SUBE && piso_q != 2'd3) begin
            piso_d = piso_q + 2'd1;
          end else if (dir_q == DIR_BAJA && piso_q != 2'd0) begin
            piso_d = piso_q - 2'd1;
          end
          if (pend_q[piso_d]) begin
            estado_d = PUERTAS;
            dir_d    = DIR_REPOSO;
          end else if ((dir_q == DIR_SUBE && piso_d == 2'd3) ||
                       (dir_q == DIR_BAJA && piso_d == 2'd0)) begin
            estado_d = REPOSO;
            dir_d    = DIR_REPOSO;
          end
        end
      end
      PUERTAS: begin
        dir_d = DIR_REPOSO;
        if (!boton_piso[piso_q] && fin_puerta) begin
          estado_d = REPOSO;
        end
      end
      default: begin
        estado_d = REPOSO;
        dir_d    = DIR_REPOSO;
      end
    endcase
    // Served floor's call is dropped on entry and kept dropped while open.
    if (estado_d == PUERTAS) begin
      pend_d[piso_d] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= REPOSO;
      piso_q   <= 2'd0;
      dir_q    <= DIR_REPOSO;
      ult_q    <= 1'b1;
      pend_q   <= '0;
    end else begin
      estado_q <= estado_d;
      piso_q   <= piso_d;
      dir_q    <= dir_d;
      ult_q    <= ult_d;
      pend_q   <= pend_d;
    end
  end

  assign piso             = piso_q;
  assign direccion        = dir_q;
  assign puertas_abiertas = (estado_q == PUERTAS);
  assign state_andando    = (estado_q == MOVIENDO);
  assign pendientes       = pend_q;

endmodule

// File: doc/planificador_ascensor.md
PLANIFICADOR_ASCENSOR -- requirements
Module: planificador_ascensor

Interface
REQ-001 Parameter T_VIAJE, default 4: tick pulses to travel one floor (legal range 1..15).
REQ-002 Parameter T_PUERTA, default 3: tick pulses doors stay open (legal range 1..15).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 tick  input  1  one-clk-wide timing enable from the clock divider; it is the only source of travel and door timing.
REQ-006 boton_piso  input  4  floor-call buttons, one bit per floor 0..3, sampled every clk.
REQ-007 piso  output  2  current floor, 0..3.
REQ-008 direccion  output  2  00 idle, 01 up, 10 down; 11 is never driven.
REQ-009 puertas_abiertas  output  1  high in PUERTAS state.
REQ-010 state_andando  output  1  high in MOVIENDO state.
REQ-011 pendientes  output  4  registered pending-call vector.

Function
REQ-012 FSM states SHALL be REPOSO, MOVIENDO and PUERTAS, with an internal ultima_dir register (up/down).
REQ-013 Any boton_piso[i]=1 on a clk edge SHALL set pendientes[i] on that edge; setting is the only effect of a button.
REQ-014 pendientes[piso] SHALL clear on the edge entering PUERTAS; while in PUERTAS, boton_piso[piso] SHALL NOT set the bit (clear wins) and SHALL reload the door timer.
REQ-015 REPOSO, pendientes[piso]=1: next state SHALL be PUERTAS.
REQ-016 REPOSO, no call at piso but calls above/below: direccion SHALL become ultima_dir if calls exist that way, else the opposite; ultima_dir updated; enter MOVIENDO with travel counter 0.
REQ-017 REPOSO, pendientes=0: stay; direccion=00.
REQ-018 MOVIENDO: each tick SHALL increment the travel counter; on the tick reaching T_VIAJE, piso SHALL step by +/-1 and the counter reset to 0 on that same edge.
REQ-019 After a step, if pendientes[new piso]=1 next state SHALL be PUERTAS, otherwise MOVIENDO continues in the same direction.
REQ-020 piso SHALL never wrap: no up-step from 3, no down-step from 0.
REQ-021 PUERTAS: direccion=00; the door counter counts ticks; on the T_PUERTA-th tick, next state SHALL be REPOSO, which re-evaluates on the following edge.
REQ-022 Call-to-response latency at the current floor from REPOSO SHALL be 2 clk edges: set pendientes, then enter PUERTAS.
REQ-023 With tick held 0, piso, the counters and the state SHALL hold (except REPOSO decisions and pendientes updates).

Reset
REQ-024 rst=1 SHALL immediately force: state REPOSO, piso=0, direccion=00, puertas_abiertas=0, state_andando=0, pendientes=0, both counters 0, ultima_dir=up. This applies in any state, including mid-travel.
REQ-025 Buttons sampled while rst=1 SHALL be discarded.

Structure
REQ-026 The shared package SHALL hold N_PISOS=4, the direction codes DIR_REPOSO/DIR_SUBE/DIR_BAJA, and the FSM state enumeration.
REQ-027 Travel and door timing SHALL use a sub-module temporizador_tick (load, tick enable, 4-bit count, done flag), instantiated twice.
REQ-028 The above/below call detection SHALL be combinational masks of pendientes relative to piso.

Verification (T_VIAJE=2, T_PUERTA=2, tick=1 every clk unless stated)
REQ-029 From reset, pulse boton_piso=1000 -> next edge direccion=01 and state_andando=1; piso 1,2,3 every 2 clk; doors open at 3; pendientes=0000; REPOSO 2 clk later with direccion=00.
REQ-030 Moving up past piso 1 toward 3, pulse 0101 -> stops at 2, then 3, then reverses (direccion=10), and stops at 0.
REQ-031 Idle at piso 1 with ultima_dir=up, pulse 0101 in a single clk -> goes up to 2 first, then down to 0.
REQ-032 In PUERTAS at piso 2, pulse 0100 each clk -> doors stay open while pulsed, pendientes[2] stays 0, close T_PUERTA ticks after the last pulse.
REQ-033 Assert rst mid-step between floors 1 and 2 -> all outputs zero before the next clk edge; a button pressed during rst is ignored.
REQ-034 tick=0 during MOVIENDO for 10 clk -> piso and state unchanged; travel resumes when tick returns.
